// File: rtl/simmem_bank_scheduler_pkg.sv
// Shared types and constants for the simulated-memory bank scheduler:
// address/id widths, default access costs, FSM state encoding.
package simmem_bank_scheduler_pkg;

  localparam int AxAddrWidth    = 16;
  localparam int RowBufLenW     = 8;
  localparam int RowIdWidth     = AxAddrWidth - RowBufLenW;
  localparam int WRspBankAddrW  = 3;
  localparam int RDataBankAddrW = 4;
  localparam int SchedIidW      = (WRspBankAddrW > RDataBankAddrW) ? WRspBankAddrW : RDataBankAddrW;
  localparam int DelayW         = 6;

  localparam int unsigned DefRowHitCost     = 4;
  localparam int unsigned DefPrechargeCost  = 2;
  localparam int unsigned DefActivationCost = 1;

  typedef logic [WRspBankAddrW-1:0]  write_iid_t;
  typedef logic [RDataBankAddrW-1:0] read_iid_t;
  typedef logic [RowIdWidth-1:0]     row_id_t;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    ACCESS,
    DONE
  } sched_state_e;

  function automatic row_id_t row_of(input logic [AxAddrWidth-1:0] addr);
    return addr[AxAddrWidth-1:RowBufLenW];
  endfunction

endpackage

// File: rtl/simmem_rr_arb2.sv
// Two-requester round-robin arbiter. A single priority flop selects the
// preferred side on contention and moves to the other side after every grant.
module simmem_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic prio_b_q;  // 0: side a wins a tie, 1: side b wins a tie

  assign gnt_a_o = en_i & req_a_i & (~req_b_i | ~prio_b_q);
  assign gnt_b_o = en_i & req_b_i & (~req_a_i |  prio_b_q);

  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_b_q <= 1'b0;
    end else if (gnt_a_o) begin
      prio_b_q <= 1'b1;
    end else if (gnt_b_o) begin
      prio_b_q <= 1'b0;
    end
  end

endmodule

// File: rtl/simmem_bank_scheduler.sv
// Single-bank access scheduler: arbitrates write/read address requests, models
// open-page row costs and emits a completion token. Optional row statistics
// are enabled with SIMMEM_BANK_SCHED_STATS_EN.
module simmem_bank_scheduler
  import simmem_bank_scheduler_pkg::*;
#(
  parameter int unsigned RowHitCost     = DefRowHitCost,
  parameter int unsigned PrechargeCost  = DefPrechargeCost,
  parameter int unsigned ActivationCost = DefActivationCost,
  parameter int          CntW           = DelayW,
  parameter int          StatsW         = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxAddrWidth-1:0]    w_addr_i,
  input  logic [WRspBankAddrW-1:0]  w_iid_i,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AxAddrWidth-1:0]    r_addr_i,
  input  logic [RDataBankAddrW-1:0] r_iid_i,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  output logic                      done_is_write_o,
  output logic [SchedIidW-1:0]      done_iid_o,
  output logic [StatsW-1:0]         row_hit_cnt_o,
  output logic [StatsW-1:0]         row_miss_cnt_o
);

  if (RowHitCost < 3 || PrechargeCost == 0 || ActivationCost == 0 ||
      RowHitCost > (1 << CntW) || PrechargeCost > (1 << CntW) ||
      ActivationCost > (1 << CntW)) begin : g_bad_cost
    $error("simmem_bank_scheduler: illegal cost parameter");
  end

  localparam logic [CntW-1:0] HitLoad = CntW'(RowHitCost - 1);
  localparam logic [CntW-1:0] PreLoad = CntW'(PrechargeCost - 1);
  localparam logic [CntW-1:0] ActLoad = CntW'(ActivationCost - 1);

  sched_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 row_open_q, row_open_d;
  row_id_t              open_row_q, open_row_d;
  row_id_t              lat_row_q;
  logic                 lat_is_w_q;
  logic [SchedIidW-1:0] lat_iid_q;

  logic    gnt_w, gnt_r, w_hs, r_hs, hs, row_hit;
  row_id_t req_row;

  simmem_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (state_q == IDLE),
    .req_a_i (w_valid_i),
    .req_b_i (r_valid_i),
    .gnt_a_o (gnt_w),
    .gnt_b_o (gnt_r)
  );

  // Ready is forced low while reset is asserted so every output reads 0.
  assign w_ready_o = rst_ni & gnt_w;
  assign r_ready_o = rst_ni & gnt_r;
  assign w_hs      = w_ready_o;
  assign r_hs      = r_ready_o;
  assign hs        = w_hs | r_hs;
  assign req_row   = w_hs ? row_of(w_addr_i) : row_of(r_addr_i);
  assign row_hit   = row_open_q && (req_row == open_row_q);

  // NOTE: every signal assigned here gets a default first, which rules out
  // inferred latches on paths that do not assign it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (row_hit) begin
            state_d = ACCESS;
            cnt_d   = HitLoad;
          end else if (row_open_q) begin
            state_d = PRECHARGE;
            cnt_d   = PreLoad;
          end else begin
            state_d = ACTIVATE;
            cnt_d   = ActLoad;
          end
        end
      end
      PRECHARGE: begin
        if (cnt_q == '0) begin
          state_d    = ACTIVATE;
          cnt_d      = ActLoad;
          row_open_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ACTIVATE: begin
        if (cnt_q == '0) begin
          state_d    = ACCESS;
          cnt_d      = HitLoad;
          row_open_d = 1'b1;
          open_row_d = lat_row_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      lat_row_q  <= '0;
      lat_is_w_q <= 1'b0;
      lat_iid_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      if (hs) begin
        lat_row_q  <= req_row;
        lat_is_w_q <= w_hs;
        lat_iid_q  <= w_hs ? SchedIidW'(w_iid_i) : SchedIidW'(r_iid_i);
      end
    end
  end

  assign done_valid_o    = (state_q == DONE);
  assign done_is_write_o = lat_is_w_q;
  assign done_iid_o      = lat_iid_q;

`ifdef SIMMEM_BANK_SCHED_STATS_EN
  logic [StatsW-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (hs) begin
      if (row_hit && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + StatsW'(1);
      end
      if (!row_hit && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + StatsW'(1);
      end
    end
  end

  assign row_hit_cnt_o  = hit_cnt_q;
  assign row_miss_cnt_o = miss_cnt_q;
`else
  assign row_hit_cnt_o  = '0;
  assign row_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_simmem_bank_scheduler.sv
// Directed self-checking bench for simmem_bank_scheduler: latency per row
// outcome, round-robin ordering, completion backpressure and mid-flight reset.
module tb_simmem_bank_scheduler;
  import simmem_bank_scheduler_pkg::*;

`ifdef SIMMEM_BANK_SCHED_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      w_valid_i, r_valid_i, done_ready_i;
  logic                      w_ready_o, r_ready_o;
  logic [AxAddrWidth-1:0]    w_addr_i, r_addr_i;
  logic [WRspBankAddrW-1:0]  w_iid_i;
  logic [RDataBankAddrW-1:0] r_iid_i;
  logic                      done_valid_o, done_is_write_o;
  logic [SchedIidW-1:0]      done_iid_o;
  logic [15:0]               row_hit_cnt_o, row_miss_cnt_o;

  int passed = 0;
  int total  = 0;

  simmem_bank_scheduler dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .w_valid_i       (w_valid_i),
    .w_ready_o       (w_ready_o),
    .w_addr_i        (w_addr_i),
    .w_iid_i         (w_iid_i),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o),
    .r_addr_i        (r_addr_i),
    .r_iid_i         (r_iid_i),
    .done_valid_o    (done_valid_o),
    .done_ready_i    (done_ready_i),
    .done_is_write_o (done_is_write_o),
    .done_iid_o      (done_iid_o),
    .row_hit_cnt_o   (row_hit_cnt_o),
    .row_miss_cnt_o  (row_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic apply_reset();
    rst_ni       = 1'b0;
    w_valid_i    = 1'b0;
    r_valid_i    = 1'b0;
    done_ready_i = 1'b0;
    w_addr_i     = '0;
    r_addr_i     = '0;
    w_iid_i      = '0;
    r_iid_i      = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Issues one request, measures cycles from handshake edge to done_valid_o,
  // checks the token, then consumes it.
  task automatic do_req(input logic is_w, input logic [15:0] addr,
                        input logic [3:0] iid, input int exp_lat, input string name);
    int lat;
    logic [SchedIidW-1:0] exp_iid;
    exp_iid = is_w ? {1'b0, iid[2:0]} : iid;
    if (is_w) begin
      w_valid_i = 1'b1; w_addr_i = addr; w_iid_i = iid[2:0];
    end else begin
      r_valid_i = 1'b1; r_addr_i = addr; r_iid_i = iid;
    end
    #1;
    total++;
    if ((is_w ? w_ready_o : r_ready_o) !== 1'b1)
      $display("FAIL %s_ready: got %b want 1", name, is_w ? w_ready_o : r_ready_o);
    else passed++;
    @(posedge clk_i);
    #1;
    w_valid_i = 1'b0;
    r_valid_i = 1'b0;
    lat = 0;
    while (done_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    total++;
    if (lat != exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    else passed++;
    total++;
    if (done_is_write_o !== is_w || done_iid_o !== exp_iid)
      $display("FAIL %s_token: got w=%b iid=%0h want w=%b iid=%0h",
               name, done_is_write_o, done_iid_o, is_w, exp_iid);
    else passed++;
    done_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    done_ready_i = 1'b0;
    total++;
    if (done_valid_o !== 1'b0) $display("FAIL %s_consumed: done_valid got %b want 0", name, done_valid_o);
    else passed++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    w_valid_i = 1'b0; r_valid_i = 1'b0; done_ready_i = 1'b0;
    w_addr_i = '0; r_addr_i = '0; w_iid_i = '0; r_iid_i = '0;
    #2;
    total++;
    if ({w_ready_o, r_ready_o, done_valid_o, done_is_write_o, done_iid_o,
         row_hit_cnt_o, row_miss_cnt_o} !== '0)
      $display("FAIL reset_outputs: got rdy=%b%b dv=%b w=%b iid=%0h hit=%0d miss=%0d want all 0",
               w_ready_o, r_ready_o, done_valid_o, done_is_write_o, done_iid_o,
               row_hit_cnt_o, row_miss_cnt_o);
    else passed++;
    apply_reset();
  endtask

  task automatic test_row_costs();
    apply_reset();
    do_req(1'b1, 16'h0100, 4'd5, 5, "closed_write");
    total++;
    if (row_miss_cnt_o !== (StatsOn ? 16'd1 : 16'd0))
      $display("FAIL closed_miss_cnt: got %0d want %0d", row_miss_cnt_o, StatsOn ? 1 : 0);
    else passed++;
    do_req(1'b0, 16'h01FC, 4'd9, 4, "hit_read");
    total++;
    if (row_hit_cnt_o !== (StatsOn ? 16'd1 : 16'd0))
      $display("FAIL hit_cnt: got %0d want %0d", row_hit_cnt_o, StatsOn ? 1 : 0);
    else passed++;
    do_req(1'b0, 16'h0200, 4'd3, 7, "conflict_read");
    total++;
    if (row_miss_cnt_o !== (StatsOn ? 16'd2 : 16'd0))
      $display("FAIL conflict_miss_cnt: got %0d want %0d", row_miss_cnt_o, StatsOn ? 2 : 0);
    else passed++;
  endtask

  task automatic test_round_robin();
    int w_left, r_left, n_done, cyc;
    bit both_ready;
    logic [4:0] got [8];
    apply_reset();
    w_left = 4; r_left = 4; n_done = 0; both_ready = 1'b0;
    w_addr_i = 16'h0100;
    r_addr_i = 16'h0180;
    done_ready_i = 1'b1;
    for (cyc = 0; cyc < 300 && n_done < 8; cyc++) begin
      w_valid_i = (w_left > 0);
      r_valid_i = (r_left > 0);
      w_iid_i   = 3'(4 - w_left);
      r_iid_i   = 4'(12 - r_left);
      #1;
      if (w_ready_o && r_ready_o) both_ready = 1'b1;
      if (w_ready_o) w_left--;
      if (r_ready_o) r_left--;
      if (done_valid_o) begin
        got[n_done] = {done_is_write_o, done_iid_o};
        n_done++;
      end
      @(posedge clk_i);
      #1;
    end
    w_valid_i = 1'b0; r_valid_i = 1'b0; done_ready_i = 1'b0;
    total++;
    if (n_done != 8 || both_ready) $display("FAIL rr_progress: got %0d completions dual_ready=%b want 8, 0", n_done, both_ready);
    else passed++;
    for (int i = 0; i < n_done; i++) begin
      logic [4:0] exp;
      exp = (i % 2 == 0) ? {1'b1, 4'(i / 2)} : {1'b0, 4'(8 + i / 2)};
      total++;
      if (got[i] !== exp) $display("FAIL rr_order_%0d: got w=%b iid=%0h want w=%b iid=%0h",
                                   i, got[i][4], got[i][3:0], exp[4], exp[3:0]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    apply_reset();
    w_valid_i = 1'b1; w_addr_i = 16'h0100; w_iid_i = 3'd2;
    @(posedge clk_i);
    #1;
    w_valid_i = 1'b0;
    lat = 0;
    while (done_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    w_valid_i = 1'b1; w_addr_i = 16'h0140; w_iid_i = 3'd6;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (done_valid_o !== 1'b1 || done_is_write_o !== 1'b1 || done_iid_o !== 4'd2 || w_ready_o !== 1'b0)
        $display("FAIL bp_hold_%0d: got dv=%b w=%b iid=%0h wrdy=%b want 1 1 2 0",
                 i, done_valid_o, done_is_write_o, done_iid_o, w_ready_o);
      else passed++;
      @(posedge clk_i);
    end
    #1 done_ready_i = 1'b1;
    #1;
    total++;
    if (w_ready_o !== 1'b0) $display("FAIL bp_no_bypass: w_ready got %b want 0", w_ready_o);
    else passed++;
    @(posedge clk_i);
    #1 done_ready_i = 1'b0;
    #1;
    total++;
    if (done_valid_o !== 1'b0 || w_ready_o !== 1'b1)
      $display("FAIL bp_accept_next: got dv=%b wrdy=%b want 0 1", done_valid_o, w_ready_o);
    else passed++;
    @(posedge clk_i);
    #1 w_valid_i = 1'b0;
    lat = 0;
    while (done_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    total++;
    if (lat != 4 || done_iid_o !== 4'd6)
      $display("FAIL bp_second: got lat=%0d iid=%0h want 4 6", lat, done_iid_o);
    else passed++;
    done_ready_i = 1'b1;
    @(posedge clk_i);
    #1 done_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_req(1'b1, 16'h0100, 4'd1, 5, "pre_open");
    r_valid_i = 1'b1; r_addr_i = 16'h0300; r_iid_i = 4'd4;
    @(posedge clk_i);
    #1 r_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    total++;
    if ({w_ready_o, r_ready_o, done_valid_o, done_is_write_o, done_iid_o,
         row_hit_cnt_o, row_miss_cnt_o} !== '0)
      $display("FAIL midreset_outputs: got dv=%b w=%b iid=%0h hit=%0d miss=%0d want all 0",
               done_valid_o, done_is_write_o, done_iid_o, row_hit_cnt_o, row_miss_cnt_o);
    else passed++;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    do_req(1'b1, 16'h0100, 4'd7, 5, "after_reset");
  endtask

  initial begin
    test_reset();
    test_row_costs();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simmem_bank_scheduler.md
Name: simmem_bank_scheduler

Overview:
Single-bank access scheduler for the simulated memory. It arbitrates between write-address and read-address requests, tracks the open row of the bank, and charges row-hit, precharge and activation costs in cycles. When the modelled access is complete, it emits a completion token carrying the request's internal identifier. It sits between the address-side request queues and the response banks, and decides when each response may be released.

Parameters:
RowHitCost, 4, cycles charged for every column access (must be at least 3)
PrechargeCost, 2, cycles to close an open row
ActivationCost, 1, cycles to open a row
CntW, DelayW (6), width of the internal cost counter
StatsW, 16, width of the statistics counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
w_valid_i  in  1  write request valid
w_ready_o  out  1  write request accepted
w_addr_i  in  AxAddrWidth  write address
w_iid_i  in  WRspBankAddrW  write internal id (write_iid_t)
r_valid_i  in  1  read request valid
r_ready_o  out  1  read request accepted
r_addr_i  in  AxAddrWidth  read address
r_iid_i  in  RDataBankAddrW  read internal id (read_iid_t)
done_valid_o  out  1  completion token valid
done_ready_i  in  1  completion consumed
done_is_write_o  out  1  1 = write completion, 0 = read completion
done_iid_o  out  max(WRspBankAddrW,RDataBankAddrW)  id of the completed request, zero-extended
row_hit_cnt_o  out  StatsW  row-hit count (feature-dependent)
row_miss_cnt_o  out  StatsW  row-miss count (feature-dependent)

Behaviour:
- Single clock clk_i; rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; FSM state IDLE; row_open = 0; priority = write; counter = 0.
- Row id is addr[AxAddrWidth-1:RowBufLenW], which is RowIdWidth bits wide.
- FSM states: IDLE, PRECHARGE, ACTIVATE, ACCESS, DONE.
- Handshake ready: w_ready_o / r_ready_o are asserted only in IDLE, and only toward the granted side.
  - Ready is combinational from the valids and may be high only when the matching valid is high.
  - At most one handshake occurs per cycle.
- Arbitration:
  - If only one side is valid, that side is granted.
  - If both are valid, the side indicated by the priority flag is granted.
  - After each grant, priority flips to the other side (round-robin).
- On a handshake, the scheduler latches the id, the direction and the row, then transitions:
  - row open and same row (hit) -> ACCESS, counter = RowHitCost-1.
  - row open and different row -> PRECHARGE, counter = PrechargeCost-1.
  - no row open -> ACTIVATE, counter = ActivationCost-1.
- Phase transitions happen when the counter reaches 0 (the counter decrements every cycle otherwise):
  - PRECHARGE -> ACTIVATE.
  - ACTIVATE -> ACCESS. The open row becomes the latched row and row_open is set.
  - ACCESS -> DONE.
- Latency: done_valid_o rises exactly C cycles after the handshake edge, where:
  - C = RowHitCost on a hit.
  - C = PrechargeCost + ActivationCost + RowHitCost on a conflict.
  - C = ActivationCost + RowHitCost when the bank is closed.
- DONE state:
  - done_valid_o = 1; done_is_write_o and done_iid_o are held stable until done_ready_i.
  - On done_valid_o && done_ready_i the FSM returns to IDLE. A new request may then be accepted on the following cycle (no same-cycle bypass).
  - Backpressure on done_ready_i stalls the scheduler indefinitely with no loss of the token.
- The row stays open after an access (open-page policy).
- Requests that are valid while the FSM is busy wait; their inputs are not sampled.
- A cost parameter equal to 0 is illegal; a static assertion is required.
- Reset asserted mid-operation: the in-flight request is dropped silently, the row is closed, and all outputs clear immediately.

Optional Feature:
SIMMEM_BANK_SCHED_STATS_EN
- Defined: row_hit_cnt_o increments on every hit handshake. row_miss_cnt_o increments on every conflict or closed-bank handshake. Both counters saturate at all-ones and reset to 0.
- Not defined: no counter flops are instantiated, and both outputs are tied to 0.

Decomposition:
- The shared package holds the cost constants, RowBufLenW, RowIdWidth, DelayW, write_iid_t and read_iid_t.
- The package also gains:
  - the FSM state enum, sched_state_e;
  - a row-id typedef, row_id_t;
  - an iid width constant, SchedIidW = max(WRspBankAddrW, RDataBankAddrW).
- One sub-module is natural: simmem_rr_arb2, a two-requester round-robin arbiter with a priority flop, reused elsewhere.

Test Plan:
- Write addr 0x0100 after reset (bank closed) -> done_valid_o 5 cycles after handshake; is_write=1; iid matches.
- Then read addr 0x01FC (row 1, hit) -> done after 4 cycles; is_write=0; hit count = 1.
- Then read addr 0x0200 (row 2, conflict) -> done after 7 cycles; miss count = 2.
- W and R both valid continuously with 4 requests each -> grants alternate W,R,W,R...; completions occur in grant order.
- Hold done_ready_i low for 10 cycles while a new w_valid_i is pending -> done outputs stable, w_ready_o stays 0, and the request is accepted on the cycle after the done handshake.
- Assert rst_ni low during PRECHARGE -> all outputs 0 at once; the next access to the previous row costs 5 cycles (bank closed).
